alu_control_mc: RTL and testbench

- Registered ALU control for the pipelined datapath, sitting at the ID/EX boundary.
- Decodes ALU_op and funct_ctrl into the ALU function code, one cycle later.
- Adds multi-cycle MULTU/DIVU sequencing:
  - a latency counter per operation;
  - a busy/stall handshake back to the issue stage;
  - a single-cycle HI/LO write strobe when the operation completes.

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_ctrl_decode.sv | 47 ++++
 rtl/alu_control_mc.sv | 108 ++++++++++
 tb/tb_alu_control_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control: ALU_op classes, funct
// constants, output ALU codes and the multi-cycle sequencer state type.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } alu_op_e;

  // Input funct field values
  localparam logic [5:0] F_ADDU  = 6'b001011;
  localparam logic [5:0] F_SUBU  = 6'b001101;
  localparam logic [5:0] F_SLL   = 6'b100110;
  localparam logic [5:0] F_SRL   = 6'b100111;
  localparam logic [5:0] F_SLLV  = 6'b110110;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Output ALU function codes
  localparam logic [5:0] C_NOP   = 6'b000000;
  localparam logic [5:0] C_ADD   = 6'b001001;
  localparam logic [5:0] C_SUB   = 6'b001010;
  localparam logic [5:0] C_SLT   = 6'b101010;
  localparam logic [5:0] C_SLL   = 6'b100001;
  localparam logic [5:0] C_SRL   = 6'b100010;
  localparam logic [5:0] C_SLLV  = 6'b110101;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mc_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU_op/funct decode: function code plus multi-cycle,
// divide and undefined-funct flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [FUNCT_W-1:0] code,
  output logic               is_mc,
  output logic               is_div,
  output logic               illegal
);

  always_comb begin
    code    = FUNCT_W'(C_NOP);
    is_mc   = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = FUNCT_W'(C_ADD);
      ALUOP_SUB: code = FUNCT_W'(C_SUB);
      ALUOP_SLT: code = FUNCT_W'(C_SLT);
      default: begin
        case (funct)
          FUNCT_W'(F_ADDU):  code = FUNCT_W'(C_ADD);
          FUNCT_W'(F_SUBU):  code = FUNCT_W'(C_SUB);
          FUNCT_W'(F_SLL):   code = FUNCT_W'(C_SLL);
          FUNCT_W'(F_SRL):   code = FUNCT_W'(C_SRL);
          FUNCT_W'(F_SLLV):  code = FUNCT_W'(C_SLLV);
          FUNCT_W'(F_MULTU): begin
            code  = FUNCT_W'(C_MULTU);
            is_mc = 1'b1;
          end
          FUNCT_W'(F_DIVU): begin
            code   = FUNCT_W'(C_DIVU);
            is_mc  = 1'b1;
            is_div = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control at ID/EX with MULTU/DIVU latency sequencing and stall.
// Optional sticky illegal-funct flag: define ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [1:0]         ALU_op,
  input  logic [FUNCT_W-1:0] funct_ctrl,
  input  logic               flush,
  output logic [FUNCT_W-1:0] funct_out,
  output logic               valid_out,
  output logic               busy,
  output logic               mc_start,
  output logic               mc_is_div,
  output logic               hilo_we,
  output logic               illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [FUNCT_W-1:0] dec_code;
  logic               dec_mc, dec_div, dec_illegal;
  logic               accept;
  mc_state_e          state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  alu_ctrl_decode #(.FUNCT_W(FUNCT_W)) u_dec (
    .alu_op  (ALU_op),
    .funct   (funct_ctrl),
    .code    (dec_code),
    .is_mc   (dec_mc),
    .is_div  (dec_div),
    .illegal (dec_illegal)
  );

  assign busy   = (state != S_IDLE);
  assign accept = valid_in & ~busy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // hilo_we is decoded from the current state, so a flush arriving in the
  // completion cycle cannot retract it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hilo_we  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && dec_mc) begin
          state_nx = dec_div ? S_DIV : S_MUL;
          cnt_nx   = dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) begin
          hilo_we  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct_out <= '0;
      valid_out <= 1'b0;
      mc_start  <= 1'b0;
      mc_is_div <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      valid_out <= accept;
      mc_start  <= accept & dec_mc;
      if (accept) funct_out <= dec_code;
      // Type is held through completion so hilo_we consumers can use it.
      if (accept && dec_mc) mc_is_div <= dec_div;
      illegal <= illegal | (TRAP_EN & accept & dec_illegal);
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed, table-driven bench for alu_control_mc (default MUL_LAT=4, DIV_LAT=32).
module tb_alu_control_mc;
  logic       clk, rst_n, valid_in, flush;
  logic [1:0] ALU_op;
  logic [5:0] funct_ctrl, funct_out;
  logic       valid_out, busy, mc_start, mc_is_div, hilo_we, illegal;

  int checks = 0;
  int failures = 0;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic [31:0] EXP_ILL = 32'd1;
`else
  localparam logic [31:0] EXP_ILL = 32'd0;
`endif

  alu_control_mc dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALU_op(ALU_op),
    .funct_ctrl(funct_ctrl), .flush(flush), .funct_out(funct_out),
    .valid_out(valid_out), .busy(busy), .mc_start(mc_start),
    .mc_is_div(mc_is_div), .hilo_we(hilo_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic fl);
    valid_in   = v;
    ALU_op     = op;
    funct_ctrl = fn;
    flush      = fl;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_funct"}, 32'(funct_out), 0);
    chk({nm, "_valid"}, 32'(valid_out), 0);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_start"}, 32'(mc_start), 0);
    chk({nm, "_isdiv"}, 32'(mc_is_div), 0);
    chk({nm, "_hilo"},  32'(hilo_we), 0);
    chk({nm, "_ill"},   32'(illegal), 0);
  endtask

  initial begin
    logic hw;
    logic bz;
    vecs[0]  = '{2'b10, 6'b001011, 6'b001001};
    vecs[1]  = '{2'b11, 6'b000000, 6'b101010};
    vecs[2]  = '{2'b00, 6'b111111, 6'b001001};
    vecs[3]  = '{2'b01, 6'b000000, 6'b001010};
    vecs[4]  = '{2'b10, 6'b001101, 6'b001010};
    vecs[5]  = '{2'b10, 6'b100110, 6'b100001};
    vecs[6]  = '{2'b10, 6'b100111, 6'b100010};
    vecs[7]  = '{2'b10, 6'b110110, 6'b110101};
    vecs[8]  = '{2'b10, 6'b000000, 6'b000000};
    vecs[9]  = '{2'b10, 6'b101010, 6'b000000};
    vecs[10] = '{2'b11, 6'b001011, 6'b101010};
    vecs[11] = '{2'b00, 6'b011001, 6'b001001};

    rst_n = 1'b0;
    drv(0, 2'b00, 6'b0, 0);
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back decode, no bubbles
    for (int i = 0; i < 12; i++) begin
      drv(1, vecs[i].op, vecs[i].fn, 0);
      tick();
      chk($sformatf("vec%0d_funct", i), 32'(funct_out), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_valid", i), 32'(valid_out), 1);
    end
    chk("vec_no_mc_busy", 32'(busy), 0);
    drv(0, 2'b10, 6'b001011, 0);
    tick();
    chk("idle_valid", 32'(valid_out), 0);
    chk("idle_hold", 32'(funct_out), 32'h09);

    // MULTU, LAT=4; ADDU held during stall
    drv(1, 2'b10, 6'b011001, 0);
    tick();
    drv(1, 2'b10, 6'b001011, 0);
    chk("mul_funct", 32'(funct_out), 32'h19);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_busy_%0d", k), 32'(busy), 1);
      chk($sformatf("mul_start_%0d", k), 32'(mc_start), (k == 1) ? 1 : 0);
      chk($sformatf("mul_hilo_%0d", k), 32'(hilo_we), (k == 4) ? 1 : 0);
      chk($sformatf("mul_valid_%0d", k), 32'(valid_out), (k == 1) ? 1 : 0);
      if (k == 1 || k == 4) chk($sformatf("mul_isdiv_%0d", k), 32'(mc_is_div), 0);
      tick();
    end
    chk("mul_t5_busy", 32'(busy), 0);
    chk("mul_t5_hilo", 32'(hilo_we), 0);
    chk("mul_t5_valid", 32'(valid_out), 0);
    tick();
    chk("mul_t6_valid", 32'(valid_out), 1);
    chk("mul_t6_funct", 32'(funct_out), 32'h09);
    drv(0, 2'b00, 6'b0, 0);
    tick();

    // DIVU aborted by flush in cycle T+10
    drv(1, 2'b10, 6'b011011, 0);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    chk("div_start", 32'(mc_start), 1);
    chk("div_isdiv", 32'(mc_is_div), 1);
    hw = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      hw |= hilo_we;
      tick();
    end
    chk("div_t10_busy", 32'(busy), 1);
    drv(0, 2'b00, 6'b0, 1);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    chk("div_flush_busy", 32'(busy), 0);
    chk("div_flush_valid", 32'(valid_out), 0);
    for (int k = 0; k < 40; k++) begin
      hw |= hilo_we;
      tick();
    end
    chk("div_no_hilo", 32'(hw), 0);
    drv(1, 2'b10, 6'b001101, 0);
    tick();
    chk("subu_valid", 32'(valid_out), 1);
    chk("subu_funct", 32'(funct_out), 32'h0a);

    // flush + valid_in same cycle: input dropped
    drv(1, 2'b10, 6'b110110, 1);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    chk("fv_valid", 32'(valid_out), 0);
    chk("fv_funct", 32'(funct_out), 32'h0a);
    chk("fv_busy", 32'(busy), 0);

    // flush coinciding with hilo_we: strobe stands
    drv(1, 2'b10, 6'b011001, 0);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    tick(); tick(); tick();
    chk("fh_hilo_pre", 32'(hilo_we), 1);
    drv(0, 2'b00, 6'b0, 1);
    #1;
    chk("fh_hilo_stands", 32'(hilo_we), 1);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    chk("fh_busy_after", 32'(busy), 0);
    chk("fh_hilo_after", 32'(hilo_we), 0);

    // Asynchronous reset in T+2 of MULTU
    drv(1, 2'b10, 6'b011001, 0);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst_n = 1'b1;
    hw = 1'b0;
    bz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      hw |= hilo_we;
      bz |= busy;
    end
    chk("rst_no_hilo", 32'(hw), 0);
    chk("rst_no_busy", 32'(bz), 0);

    // Undefined funct: illegal flag (build dependent), sticky
    drv(1, 2'b10, 6'b111111, 0);
    tick();
    chk("ill_funct", 32'(funct_out), 0);
    chk("ill_valid", 32'(valid_out), 1);
    chk("ill_flag", 32'(illegal), EXP_ILL);
    drv(1, 2'b00, 6'b0, 0);
    tick();
    drv(0, 2'b00, 6'b0, 0);
    chk("ill_next_funct", 32'(funct_out), 32'h09);
    chk("ill_sticky1", 32'(illegal), EXP_ILL);
    tick(); tick(); tick();
    chk("ill_sticky2", 32'(illegal), EXP_ILL);
    #2 rst_n = 1'b0;
    #1;
    chk("ill_cleared", 32'(illegal), 0);
    #2 rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
